// File: rtl/spectrum_frame_sequencer_pkg.sv
// Shared types for the spectrum frame sequencer:
// phase encoding and buffer port-select codes.
package spectrum_frame_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SEARCH,
        ST_WAIT_OUT,
        ST_ADAPT
    } state_e;

    localparam logic [1:0] SEL_FFT   = 2'd0;
    localparam logic [1:0] SEL_MAX   = 2'd1;
    localparam logic [1:0] SEL_ADAPT = 2'd2;

    localparam logic OUT_SEL_ADAPT = 1'b0;
    localparam logic OUT_SEL_VGA   = 1'b1;

    // Phases that wait on an external block and so need a watchdog.
    function automatic logic is_watched(state_e s);
        return (s == ST_SEARCH) || (s == ST_WAIT_OUT) || (s == ST_ADAPT);
    endfunction

endpackage

// File: rtl/spectrum_frame_sequencer_if.sv
// Control bus between the sequencer and the FFT,
// max finder, adapter and VGA controller.
interface spectrum_frame_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             fft_wr_i;
    logic             in_wr_en_o;
    logic             in_ready_o;
    logic [1:0]       in_sel_o;
    logic             search_start_o;
    logic             max_found_i;
    logic             adapt_start_o;
    logic             adapt_done_i;
    logic             out_sel_o;
    logic             vga_reading_i;
    logic             display_start_o;
    logic             busy_o;
    logic             err_o;
    logic [CNT_W-1:0] frame_cnt_o;
    logic [CNT_W-1:0] drop_cnt_o;
    logic [CNT_W-1:0] err_cnt_o;

    modport master (
        input  fft_wr_i, max_found_i, adapt_done_i, vga_reading_i,
        output in_wr_en_o, in_ready_o, in_sel_o, search_start_o,
        output adapt_start_o, out_sel_o, display_start_o, busy_o,
        output err_o, frame_cnt_o, drop_cnt_o, err_cnt_o
    );

    modport slave (
        output fft_wr_i, max_found_i, adapt_done_i, vga_reading_i,
        input  in_wr_en_o, in_ready_o, in_sel_o, search_start_o,
        input  adapt_start_o, out_sel_o, display_start_o, busy_o,
        input  err_o, frame_cnt_o, drop_cnt_o, err_cnt_o
    );
endinterface

// File: rtl/spectrum_frame_sequencer_sat_counter.sv
// Saturating event counter with synchronous clear;
// holds at all-ones instead of wrapping.
module spectrum_frame_sequencer_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: step only while below the ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register, clear has priority.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/spectrum_frame_sequencer.sv
// Frame sequencer: FFT fill, max search, width adaptation,
// display hand-off, with busy-drop and phase watchdog.
module spectrum_frame_sequencer
    import spectrum_frame_sequencer_pkg::*;
#(
    parameter int BEATS       = 512,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    spectrum_frame_sequencer_if.master    bus
);
    localparam int BW = $clog2(BEATS + 1);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYC - 1);

    state_e        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          search_start_q, search_start_d;
    logic          adapt_start_q, adapt_start_d;
    logic          display_start_q, display_start_d;
    logic          err_q, err_d;

    logic in_ready;
    logic wd_hit;
    logic timeout;
    logic frame_done;
    logic drop;

    // Phase sequencing, watchdog and start-pulse generation.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        timeout    = 1'b0;
        frame_done = 1'b0;
        in_ready   = (state_q == ST_IDLE) || (state_q == ST_FILL);
        wd_hit     = (wd_q == WD_LAST);
        unique case (state_q)
            ST_IDLE, ST_FILL: begin
                if (bus.fft_wr_i) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_SEARCH;
                        beat_d  = '0;
                    end else begin
                        state_d = ST_FILL;
                        beat_d  = beat_q + 1'b1;
                    end
                end
            end
            ST_SEARCH: begin
                if (bus.max_found_i && !search_start_q) begin
                    state_d = ST_WAIT_OUT;
                end else if (wd_hit) begin
                    state_d = ST_IDLE;
                    timeout = 1'b1;
                end
            end
            ST_WAIT_OUT: begin
                if (!bus.vga_reading_i) begin
                    state_d = ST_ADAPT;
                end else if (wd_hit) begin
                    state_d = ST_IDLE;
                    timeout = 1'b1;
                end
            end
            ST_ADAPT: begin
                if (bus.adapt_done_i && !adapt_start_q) begin
                    state_d    = ST_IDLE;
                    frame_done = 1'b1;
                end else if (wd_hit) begin
                    state_d = ST_IDLE;
                    timeout = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase

        if ((state_d != state_q) || !is_watched(state_q)) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + 1'b1;
        end

        search_start_d  = (state_d == ST_SEARCH) && (state_q != ST_SEARCH);
        adapt_start_d   = (state_d == ST_ADAPT) && (state_q != ST_ADAPT);
        display_start_d = frame_done;
        err_d           = err_q | timeout;
        drop            = bus.fft_wr_i & ~in_ready;
    end

    // Sequencer registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            beat_q          <= '0;
            wd_q            <= '0;
            search_start_q  <= 1'b0;
            adapt_start_q   <= 1'b0;
            display_start_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            beat_q          <= beat_d;
            wd_q            <= wd_d;
            search_start_q  <= search_start_d;
            adapt_start_q   <= adapt_start_d;
            display_start_q <= display_start_d;
            err_q           <= err_d;
        end
    end

    // Buffer port ownership follows the current phase.
    always_comb begin
        bus.in_sel_o = SEL_FFT;
        unique case (state_q)
            ST_SEARCH:   bus.in_sel_o = SEL_MAX;
            ST_WAIT_OUT: bus.in_sel_o = SEL_ADAPT;
            ST_ADAPT:    bus.in_sel_o = SEL_ADAPT;
            default:     bus.in_sel_o = SEL_FFT;
        endcase
        bus.out_sel_o = (state_q == ST_ADAPT) ? OUT_SEL_ADAPT
                                              : OUT_SEL_VGA;
    end

    assign bus.in_ready_o      = in_ready;
    assign bus.in_wr_en_o      = bus.fft_wr_i & in_ready;
    assign bus.search_start_o  = search_start_q;
    assign bus.adapt_start_o   = adapt_start_q;
    assign bus.display_start_o = display_start_q;
    assign bus.busy_o          = (state_q != ST_IDLE);
    assign bus.err_o           = err_q;

    spectrum_frame_sequencer_sat_counter #(.W(CNT_W)) u_frame_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (frame_done),
        .cnt_o (bus.frame_cnt_o)
    );

    spectrum_frame_sequencer_sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (drop),
        .cnt_o (bus.drop_cnt_o)
    );

    spectrum_frame_sequencer_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (timeout),
        .cnt_o (bus.err_cnt_o)
    );
endmodule
